// File: rtl/dram_arbiter_mc_if.sv
// Bus bundle for the multi-channel DRAM slot arbiter: controller side,
// video fetch port and the packed client ports.
interface dram_arbiter_mc_if #(
  parameter int NCH = 4,
  parameter int AW  = 21
);
  // DRAM controller side
  logic              dram_cbeg;
  logic              dram_rrdy;
  logic [15:0]       dram_rddata;
  logic              dram_req;
  logic              dram_rnw;
  logic [AW-1:0]     dram_addr;
  logic [1:0]        dram_bsel;
  logic [15:0]       dram_wrdata;
  // video fetch port
  logic              vid_go;
  logic [1:0]        vid_bw;
  logic [AW-1:0]     vid_addr;
  logic              vid_strobe;
  // client ports
  logic [NCH-1:0]    cli_req;
  logic [NCH-1:0]    cli_rnw;
  logic [NCH*AW-1:0] cli_addr;
  logic [NCH*2-1:0]  cli_bsel;
  logic [NCH*16-1:0] cli_wrdata;
  logic [NCH-1:0]    cli_grant;
  logic [NCH-1:0]    cli_rdstrobe;
  logic [15:0]       rd_data;
  logic              tag_err;

  // arbiter view
  modport slave (
    input  dram_cbeg, dram_rrdy, dram_rddata,
    output dram_req, dram_rnw, dram_addr, dram_bsel, dram_wrdata,
    input  vid_go, vid_bw, vid_addr,
    output vid_strobe,
    input  cli_req, cli_rnw, cli_addr, cli_bsel, cli_wrdata,
    output cli_grant, cli_rdstrobe, rd_data, tag_err
  );

  // environment view (controller model, clients, video)
  modport master (
    output dram_cbeg, dram_rrdy, dram_rddata,
    input  dram_req, dram_rnw, dram_addr, dram_bsel, dram_wrdata,
    output vid_go, vid_bw, vid_addr,
    input  vid_strobe,
    output cli_req, cli_rnw, cli_addr, cli_bsel, cli_wrdata,
    input  cli_grant, cli_rdstrobe, rd_data, tag_err
  );
endinterface

// File: rtl/dram_arbiter_mc.sv
// Multi-channel DRAM slot arbiter. At every DRAM cycle boundary (dram_cbeg)
// it decides whether the slot goes to video (bandwidth share by vid_bw),
// to one of NCH clients (round-robin or fixed priority) or stays idle.
// Every issued read pushes its owner tag into a small FIFO; each dram_rrdy
// pops the oldest tag and steers the registered read data to its owner.
module dram_arbiter_mc #(
  parameter int NCH       = 4,
  parameter int AW        = 21,
  parameter int RR_MODE   = 1,
  parameter int RDQ_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  dram_arbiter_mc_if.slave bus
);
  localparam int DATA_W = 16;
  localparam int IDX_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TAG_W  = $clog2(NCH + 1);
  localparam int PTR_W  = $clog2(RDQ_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // Returns {found, index}. Round-robin scans starting just after the last
  // granted client and wraps; fixed priority scans from index 0 upward.
  function automatic logic [IDX_W:0] pick_client(input logic [NCH-1:0] elig,
                                                  input logic [IDX_W-1:0] last);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand;
    int               pos;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NCH; k++) begin
      pos  = (RR_MODE != 0) ? (int'(last) + k) % NCH : k - 1;
      cand = IDX_W'(pos);
      if (!found && elig[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  logic [1:0]       slot;
  logic [IDX_W-1:0] rr_ptr;
  logic [TAG_W-1:0] tag_mem [RDQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [TAG_W-1:0] head_tag;

  logic             vid_slot_p0;
  logic             vid_own_p0;
  logic [NCH-1:0]   elig_p0;
  logic             cli_found_p0;
  logic [IDX_W-1:0] cli_idx_p0;
  logic             push_p0;
  logic [TAG_W-1:0] push_tag_p0;
  logic             pop_p0;

  // Stage p0: slot ownership decision from current requests and FIFO state
  always_comb begin
    fifo_full   = (count == CNT_W'(RDQ_DEPTH));
    fifo_empty  = (count == '0);
    vid_slot_p0 = bus.vid_go & ((bus.vid_bw == 2'd3) |
                                ((bus.vid_bw == 2'd2) & ~slot[0]) |
                                ((bus.vid_bw == 2'd1) & (slot == 2'd0)));
    // a full tag FIFO cannot take another read, so the video slot is handed on
    vid_own_p0  = vid_slot_p0 & ~fifo_full;
    elig_p0     = bus.cli_req & ~(bus.cli_rnw & {NCH{fifo_full}});
    {cli_found_p0, cli_idx_p0} = pick_client(elig_p0, rr_ptr);
    push_p0     = bus.dram_cbeg & (vid_own_p0 | (cli_found_p0 & bus.cli_rnw[cli_idx_p0]));
    push_tag_p0 = vid_own_p0 ? TAG_W'(NCH) : TAG_W'(cli_idx_p0);
    pop_p0      = bus.dram_rrdy & ~fifo_empty;
    head_tag    = tag_mem[rd_ptr];
  end

  // Stage p1: register the slot owner's command, grant pulse, RR pointer and slot counter
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.dram_req    <= 1'b0;
      bus.dram_rnw    <= 1'b0;
      bus.dram_addr   <= '0;
      bus.dram_bsel   <= 2'b00;
      bus.dram_wrdata <= '0;
      bus.cli_grant   <= '0;
      rr_ptr          <= IDX_W'(NCH - 1);
      slot            <= 2'd0;
    end else begin
      bus.cli_grant <= '0;
      if (!bus.vid_go) begin
        slot <= 2'd0;
      end else if (bus.dram_cbeg) begin
        slot <= slot + 2'd1;
      end
      if (bus.dram_cbeg) begin
        if (vid_own_p0) begin
          bus.dram_req    <= 1'b1;
          bus.dram_rnw    <= 1'b1;
          bus.dram_addr   <= bus.vid_addr;
          bus.dram_bsel   <= 2'b11;
          bus.dram_wrdata <= '0;
        end else if (cli_found_p0) begin
          bus.dram_req    <= 1'b1;
          bus.dram_rnw    <= bus.cli_rnw[cli_idx_p0];
          bus.dram_addr   <= bus.cli_addr[cli_idx_p0*AW +: AW];
          bus.dram_bsel   <= bus.cli_rnw[cli_idx_p0] ? 2'b11 : bus.cli_bsel[cli_idx_p0*2 +: 2];
          bus.dram_wrdata <= bus.cli_wrdata[cli_idx_p0*DATA_W +: DATA_W];
          bus.cli_grant   <= NCH'(1) << cli_idx_p0;
          if (RR_MODE != 0) begin
            rr_ptr <= cli_idx_p0;
          end
        end else begin
          bus.dram_req    <= 1'b0;
          bus.dram_rnw    <= 1'b0;
          bus.dram_addr   <= '0;
          bus.dram_bsel   <= 2'b00;
          bus.dram_wrdata <= '0;
        end
      end
    end
  end

  // Tag FIFO control; simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_p0) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_p0) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_p0, pop_p0})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Tag FIFO storage; contents are meaningless once the pointers are reset
  always_ff @(posedge clk) begin
    if (push_p0) begin
      tag_mem[wr_ptr] <= push_tag_p0;
    end
  end

  // Stage p1: read return - capture data and strobe the owner of the oldest tag
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_data      <= '0;
      bus.vid_strobe   <= 1'b0;
      bus.cli_rdstrobe <= '0;
      bus.tag_err      <= 1'b0;
    end else begin
      bus.vid_strobe   <= 1'b0;
      bus.cli_rdstrobe <= '0;
      if (bus.dram_rrdy) begin
        if (fifo_empty) begin
          bus.tag_err <= 1'b1;
        end else begin
          bus.rd_data <= bus.dram_rddata;
          if (head_tag == TAG_W'(NCH)) begin
            bus.vid_strobe <= 1'b1;
          end else begin
            bus.cli_rdstrobe <= NCH'(1) << head_tag;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_dram_arbiter_mc.sv
// Bench for dram_arbiter_mc: a round-robin and a fixed-priority instance run
// side by side under independent random traffic, each checked every cycle
// against a queue-based reference model of the slot/tag rules.
module tb_dram_arbiter_mc;
  localparam int NCH   = 4;
  localparam int AW    = 21;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // stimulus, index 0 = round-robin DUT, 1 = fixed-priority DUT
  logic              cbeg   [2];
  logic              rrdy   [2];
  logic [15:0]       rddata [2];
  logic              vgo    [2];
  logic [1:0]        vbw    [2];
  logic [AW-1:0]     vaddr  [2];
  logic [NCH-1:0]    creq   [2];
  logic [NCH-1:0]    crnw   [2];
  logic [NCH*AW-1:0] caddr  [2];
  logic [NCH*2-1:0]  cbsel  [2];
  logic [NCH*16-1:0] cwr    [2];

  // observed outputs
  logic [40:0]       o_bus  [2];
  logic [NCH-1:0]    o_gnt  [2];
  logic [NCH:0]      o_stb  [2];
  logic [15:0]       o_rd   [2];
  logic              o_terr [2];

  dram_arbiter_mc_if #(.NCH(NCH), .AW(AW)) if_rr ();
  dram_arbiter_mc_if #(.NCH(NCH), .AW(AW)) if_fx ();

  assign if_rr.dram_cbeg   = cbeg[0];
  assign if_rr.dram_rrdy   = rrdy[0];
  assign if_rr.dram_rddata = rddata[0];
  assign if_rr.vid_go      = vgo[0];
  assign if_rr.vid_bw      = vbw[0];
  assign if_rr.vid_addr    = vaddr[0];
  assign if_rr.cli_req     = creq[0];
  assign if_rr.cli_rnw     = crnw[0];
  assign if_rr.cli_addr    = caddr[0];
  assign if_rr.cli_bsel    = cbsel[0];
  assign if_rr.cli_wrdata  = cwr[0];
  assign o_bus[0]  = {if_rr.dram_req, if_rr.dram_rnw, if_rr.dram_addr, if_rr.dram_bsel, if_rr.dram_wrdata};
  assign o_gnt[0]  = if_rr.cli_grant;
  assign o_stb[0]  = {if_rr.vid_strobe, if_rr.cli_rdstrobe};
  assign o_rd[0]   = if_rr.rd_data;
  assign o_terr[0] = if_rr.tag_err;

  assign if_fx.dram_cbeg   = cbeg[1];
  assign if_fx.dram_rrdy   = rrdy[1];
  assign if_fx.dram_rddata = rddata[1];
  assign if_fx.vid_go      = vgo[1];
  assign if_fx.vid_bw      = vbw[1];
  assign if_fx.vid_addr    = vaddr[1];
  assign if_fx.cli_req     = creq[1];
  assign if_fx.cli_rnw     = crnw[1];
  assign if_fx.cli_addr    = caddr[1];
  assign if_fx.cli_bsel    = cbsel[1];
  assign if_fx.cli_wrdata  = cwr[1];
  assign o_bus[1]  = {if_fx.dram_req, if_fx.dram_rnw, if_fx.dram_addr, if_fx.dram_bsel, if_fx.dram_wrdata};
  assign o_gnt[1]  = if_fx.cli_grant;
  assign o_stb[1]  = {if_fx.vid_strobe, if_fx.cli_rdstrobe};
  assign o_rd[1]   = if_fx.rd_data;
  assign o_terr[1] = if_fx.tag_err;

  dram_arbiter_mc #(.NCH(NCH), .AW(AW), .RR_MODE(1), .RDQ_DEPTH(DEPTH)) dut_rr (
    .clk(clk), .rst(rst), .bus(if_rr.slave));
  dram_arbiter_mc #(.NCH(NCH), .AW(AW), .RR_MODE(0), .RDQ_DEPTH(DEPTH)) dut_fx (
    .clk(clk), .rst(rst), .bus(if_fx.slave));

  // reference model state
  int             slot [2];
  int             ptr  [2];
  int             tq   [2][$];
  logic           terr [2];
  logic [40:0]    e_bus [2];
  logic [NCH-1:0] e_gnt [2];
  logic [NCH:0]   e_stb [2];
  logic [15:0]    e_rd  [2];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int p_req, p_cbeg, p_rrdy, p_empty, p_rst, rst_hold;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Apply one clock edge of the arbiter rules to the model of DUT d.
  task automatic model_step(input int d);
    logic full;
    logic vslot;
    int   owner;
    int   c;
    int   t;
    if (rst) begin
      e_bus[d] = '0; e_gnt[d] = '0; e_stb[d] = '0; e_rd[d] = '0;
      terr[d] = 1'b0; slot[d] = 0; ptr[d] = NCH - 1;
      tq[d].delete();
      return;
    end
    e_gnt[d] = '0;
    e_stb[d] = '0;
    full = (tq[d].size() == DEPTH);
    if (rrdy[d]) begin
      if (tq[d].size() == 0) begin
        terr[d] = 1'b1;
      end else begin
        t = tq[d].pop_front();
        e_rd[d] = rddata[d];
        e_stb[d][t] = 1'b1;
      end
    end
    if (cbeg[d]) begin
      vslot = vgo[d] && (vbw[d] == 2'd3 || (vbw[d] == 2'd2 && slot[d] % 2 == 0) ||
                         (vbw[d] == 2'd1 && slot[d] == 0));
      owner = -1;
      if (vslot && !full) begin
        owner = NCH;
      end else begin
        for (int k = 1; k <= NCH; k++) begin
          c = (d == 0) ? (ptr[d] + k) % NCH : k - 1;
          if (owner < 0 && creq[d][c] && !(crnw[d][c] && full)) owner = c;
        end
      end
      if (owner == NCH) begin
        e_bus[d] = {1'b1, 1'b1, vaddr[d], 2'b11, 16'h0000};
        tq[d].push_back(NCH);
      end else if (owner >= 0) begin
        e_bus[d] = {1'b1, crnw[d][owner], caddr[d][owner*AW +: AW],
                    crnw[d][owner] ? 2'b11 : cbsel[d][owner*2 +: 2], cwr[d][owner*16 +: 16]};
        e_gnt[d][owner] = 1'b1;
        if (d == 0) ptr[d] = owner;
        if (crnw[d][owner]) tq[d].push_back(owner);
      end else begin
        e_bus[d] = '0;
      end
      slot[d] = vgo[d] ? (slot[d] + 1) % 4 : 0;
    end else if (!vgo[d]) begin
      slot[d] = 0;
    end
  endtask

  // Randomise the environment of DUT d for the next edge.
  task automatic drive(input int d);
    for (int i = 0; i < NCH; i++) begin
      if (e_gnt[d][i]) begin
        creq[d][i] = 1'b0;
      end else if (!creq[d][i] && $urandom_range(0, 99) < p_req) begin
        creq[d][i] = 1'b1;
        crnw[d][i] = 1'($urandom_range(0, 1));
        caddr[d][i*AW +: AW] = AW'($urandom);
        cbsel[d][i*2 +: 2]   = 2'($urandom);
        cwr[d][i*16 +: 16]   = 16'($urandom);
      end
    end
    if (cyc % 64 == 0) begin
      vgo[d] = ($urandom_range(0, 3) != 0);
      vbw[d] = 2'($urandom_range(0, 3));
    end
    vaddr[d]  = AW'($urandom);
    cbeg[d]   = ($urandom_range(0, 99) < p_cbeg);
    rddata[d] = 16'($urandom);
    if (tq[d].size() > 0) rrdy[d] = ($urandom_range(0, 99) < p_rrdy);
    else                  rrdy[d] = ($urandom_range(0, 99) < p_empty);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check_val($sformatf("dram_cmd[%0d]", d), 64'(o_bus[d]), 64'(e_bus[d]));
        check_val($sformatf("cli_grant[%0d]", d), 64'(o_gnt[d]), 64'(e_gnt[d]));
        check_val($sformatf("strobes[%0d]", d), 64'(o_stb[d]), 64'(e_stb[d]));
        check_val($sformatf("rd_data[%0d]", d), 64'(o_rd[d]), 64'(e_rd[d]));
        check_val($sformatf("tag_err[%0d]", d), 64'(o_terr[d]), 64'(terr[d]));
      end
      cyc++;
      if (rst_hold > 0) begin
        rst = 1'b1;
        rst_hold--;
      end else begin
        rst = ($urandom_range(0, 999) < p_rst);
      end
      for (int d = 0; d < 2; d++) begin
        drive(d);
        model_step(d);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cbeg[d] = 1'b0; rrdy[d] = 1'b0; rddata[d] = '0;
      vgo[d] = 1'b0; vbw[d] = 2'd0; vaddr[d] = '0;
      creq[d] = '0; crnw[d] = '0; caddr[d] = '0; cbsel[d] = '0; cwr[d] = '0;
      model_step(d);
    end
    p_req = 0; p_cbeg = 0; p_rrdy = 0; p_empty = 0; p_rst = 0; rst_hold = 3;
    run(4);
    // mixed traffic
    p_req = 40; p_cbeg = 35; p_rrdy = 40;
    run(3000);
    // read data withheld: FIFO fills, only writes and idle slots follow
    p_req = 60; p_rrdy = 0;
    run(300);
    p_rrdy = 50;
    run(400);
    // saturated: back-to-back cycle boundaries, every client busy
    p_req = 100; p_cbeg = 100; p_rrdy = 30;
    run(600);
    // returns with nothing outstanding raise tag_err
    p_req = 30; p_cbeg = 40; p_empty = 30;
    run(300);
    // resets landing mid-operation with tags pending
    p_empty = 0; p_rst = 15; p_rrdy = 25;
    run(1500);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
